// File: rtl/mcu_data_pkg.sv
// Shared constants for the MicroUAZ data-side subsystem.
// Holds the IO-window offsets, control/status bit positions and FSM state codes.
package mcu_data_pkg;

  // Offsets inside the 16-word IO window at the top of the address space
  localparam logic [3:0] OFF_PORT0 = 4'd0;
  localparam logic [3:0] OFF_PIN   = 4'd8;
  localparam logic [3:0] OFF_TCNT  = 4'd12;
  localparam logic [3:0] OFF_TCMP  = 4'd13;
  localparam logic [3:0] OFF_TCTL  = 4'd14;

  // Control/status register bits
  localparam int unsigned CTL_EN_BIT   = 0;
  localparam int unsigned CTL_FLAG_BIT = 1;

  // Access FSM state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/mcu_data_subsystem_timer.sv
// mcu_timer: prescaled up-counter with compare match and sticky flag.
// Ports: i_Clk/i_Reset; i_Wr_Cmp/i_Wr_Ctl write strobes with i_Wdata;
//        o_Count, o_Compare, o_Enable, o_Flag register views.
module mcu_timer
  import mcu_data_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned PRESC  = 4
) (
  input  logic              i_Clk,
  input  logic              i_Reset,
  input  logic              i_Wr_Cmp,
  input  logic              i_Wr_Ctl,
  input  logic [DATA_W-1:0] i_Wdata,
  output logic [DATA_W-1:0] o_Count,
  output logic [DATA_W-1:0] o_Compare,
  output logic              o_Enable,
  output logic              o_Flag
);

  localparam int unsigned PRESC_W = (PRESC > 1) ? $clog2(PRESC) : 1;

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [DATA_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0]  cmp_q, cmp_d;
  logic               en_q, en_d;
  logic               flag_q, flag_d;
  logic               tick_c;

  // Next-state: the tick update follows the W1C so a same-cycle set wins
  always_comb begin
    presc_d = presc_q;
    count_d = count_q;
    cmp_d   = cmp_q;
    en_d    = en_q;
    flag_d  = flag_q;
    tick_c  = 1'b0;
    if (en_q) begin
      if (presc_q == PRESC_W'(PRESC - 1)) begin
        presc_d = '0;
        tick_c  = 1'b1;
      end else begin
        presc_d = presc_q + PRESC_W'(1);
      end
    end
    if (i_Wr_Cmp) cmp_d = i_Wdata;
    if (i_Wr_Ctl) begin
      en_d = i_Wdata[CTL_EN_BIT];
      if (i_Wdata[CTL_FLAG_BIT]) flag_d = 1'b0;
    end
    if (tick_c) begin
      if (count_q == cmp_q) begin
        count_d = '0;
        flag_d  = 1'b1;
      end else begin
        count_d = count_q + DATA_W'(1);
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      presc_q <= '0;
      count_q <= '0;
      cmp_q   <= '0;
      en_q    <= 1'b0;
      flag_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      count_q <= count_d;
      cmp_q   <= cmp_d;
      en_q    <= en_d;
      flag_q  <= flag_d;
    end
  end

  assign o_Count   = count_q;
  assign o_Compare = cmp_q;
  assign o_Enable  = en_q;
  assign o_Flag    = flag_q;

endmodule

// File: rtl/mcu_data_subsystem.sv
// mcu_data_subsystem: data RAM, output ports, synchronised input port and
// timer behind a req/ready slave with configurable wait states.
// Ports: i_Clk/i_Reset; i_Req/i_ReadWrite/i_Addr/i_Wdata request side;
//        o_Rdata/o_Ready/o_Err response; i_Port_In pins; o_Port; o_Timer_Irq.
module mcu_data_subsystem
  import mcu_data_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned RAM_DEPTH   = 192,
  parameter int unsigned N_PORTS     = 2,
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned PRESC       = 4
) (
  input  logic                      i_Clk,
  input  logic                      i_Reset,
  input  logic                      i_Req,
  input  logic                      i_ReadWrite,
  input  logic [ADDR_W-1:0]         i_Addr,
  input  logic [DATA_W-1:0]         i_Wdata,
  output logic [DATA_W-1:0]         o_Rdata,
  output logic                      o_Ready,
  output logic                      o_Err,
  input  logic [DATA_W-1:0]         i_Port_In,
  output logic [N_PORTS*DATA_W-1:0] o_Port,
  output logic                      o_Timer_Irq
);

  localparam int unsigned IO_BASE = (2 ** ADDR_W) - 16;
  localparam int unsigned RAM_AW  = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;

  logic [1:0]        state_q, state_d;
  logic [2:0]        wcnt_q, wcnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rw_q, rw_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              ready_q, ready_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] port_q [N_PORTS];
  logic [DATA_W-1:0] port_d [N_PORTS];
  logic [DATA_W-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic [DATA_W-1:0] mem [RAM_DEPTH];

  logic [3:0]        off_c;
  logic              is_ram_c, is_io_c, mapped_c;
  logic [DATA_W-1:0] rd_val_c;
  logic              mem_we_c, wr_cmp_c, wr_ctl_c;
  logic [DATA_W-1:0] t_count, t_cmp;
  logic              t_en, t_flag;

  // Address decode and read mux on the latched address
  always_comb begin
    off_c    = addr_q[3:0];
    is_ram_c = 32'(addr_q) < RAM_DEPTH;
    is_io_c  = 32'(addr_q) >= IO_BASE;
    mapped_c = is_ram_c;
    rd_val_c = '0;
    if (is_ram_c) rd_val_c = mem[RAM_AW'(addr_q)];
    if (is_io_c) begin
      for (int k = 0; k < int'(N_PORTS); k++) begin
        if (off_c == OFF_PORT0 + 4'(k)) begin
          mapped_c = 1'b1;
          rd_val_c = port_q[k];
        end
      end
      case (off_c)
        OFF_PIN:  begin mapped_c = 1'b1; rd_val_c = sync2_q; end
        OFF_TCNT: begin mapped_c = 1'b1; rd_val_c = t_count; end
        OFF_TCMP: begin mapped_c = 1'b1; rd_val_c = t_cmp;   end
        OFF_TCTL: begin
          mapped_c               = 1'b1;
          rd_val_c[CTL_EN_BIT]   = t_en;
          rd_val_c[CTL_FLAG_BIT] = t_flag;
        end
        default: ;
      endcase
    end
  end

  // Access FSM: IDLE latches the request, WAIT burns wait states, RESP commits
  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rw_d     = rw_q;
    rdata_d  = '0;
    ready_d  = 1'b0;
    err_d    = 1'b0;
    port_d   = port_q;
    sync1_d  = i_Port_In;
    sync2_d  = sync1_q;
    mem_we_c = 1'b0;
    wr_cmp_c = 1'b0;
    wr_ctl_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_Req) begin
          addr_d  = i_Addr;
          wdata_d = i_Wdata;
          rw_d    = i_ReadWrite;
          wcnt_d  = '0;
          state_d = (WAIT_STATES > 0) ? ST_WAIT : ST_RESP;
        end
      end
      ST_WAIT: begin
        if (wcnt_q == 3'(WAIT_STATES - 1)) state_d = ST_RESP;
        else wcnt_d = wcnt_q + 3'(1);
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
        err_d   = ~mapped_c;
        if (!rw_q) begin
          rdata_d = rd_val_c;
        end else begin
          mem_we_c = is_ram_c;
          wr_cmp_c = is_io_c && (off_c == OFF_TCMP);
          wr_ctl_c = is_io_c && (off_c == OFF_TCTL);
          for (int k = 0; k < int'(N_PORTS); k++) begin
            if (is_io_c && (off_c == OFF_PORT0 + 4'(k))) port_d[k] = wdata_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q <= ST_IDLE;
      wcnt_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rw_q    <= 1'b0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      port_q  <= '{default: '0};
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rw_q    <= rw_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      port_q  <= port_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  // RAM contents survive reset; a reset on the commit edge still blocks the write
  always_ff @(posedge i_Clk) begin
    if (mem_we_c && !i_Reset) mem[RAM_AW'(addr_q)] <= wdata_q;
  end

  mcu_timer #(
    .DATA_W (DATA_W),
    .PRESC  (PRESC)
  ) u_timer (
    .i_Clk     (i_Clk),
    .i_Reset   (i_Reset),
    .i_Wr_Cmp  (wr_cmp_c),
    .i_Wr_Ctl  (wr_ctl_c),
    .i_Wdata   (wdata_q),
    .o_Count   (t_count),
    .o_Compare (t_cmp),
    .o_Enable  (t_en),
    .o_Flag    (t_flag)
  );

  for (genvar k = 0; k < N_PORTS; k++) begin : g_port
    assign o_Port[k*DATA_W +: DATA_W] = port_q[k];
  end

  assign o_Rdata     = rdata_q;
  assign o_Ready     = ready_q;
  assign o_Err       = err_q;
  assign o_Timer_Irq = t_flag;

endmodule

// File: tb/tb_mcu_data_subsystem.sv
// Self-checking bench: instance A uses default parameters, instance B uses
// three wait states. Expected responses are queued at request time and
// popped when o_Ready appears.
`timescale 1ns/1ps
module tb_mcu_data_subsystem;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        a_rst, a_req, a_rw, a_ready, a_err, a_irq;
  logic [7:0]  a_addr, a_wdata, a_rdata, a_pin;
  logic [15:0] a_port;
  logic        b_rst, b_req, b_rw, b_ready, b_err, b_irq;
  logic [7:0]  b_addr, b_wdata, b_rdata, b_pin;
  logic [15:0] b_port;

  mcu_data_subsystem u_dut_a (
    .i_Clk(clk), .i_Reset(a_rst), .i_Req(a_req), .i_ReadWrite(a_rw),
    .i_Addr(a_addr), .i_Wdata(a_wdata), .o_Rdata(a_rdata), .o_Ready(a_ready),
    .o_Err(a_err), .i_Port_In(a_pin), .o_Port(a_port), .o_Timer_Irq(a_irq)
  );

  mcu_data_subsystem #(.WAIT_STATES(3)) u_dut_b (
    .i_Clk(clk), .i_Reset(b_rst), .i_Req(b_req), .i_ReadWrite(b_rw),
    .i_Addr(b_addr), .i_Wdata(b_wdata), .o_Rdata(b_rdata), .o_Ready(b_ready),
    .o_Err(b_err), .i_Port_In(b_pin), .o_Port(b_port), .o_Timer_Irq(b_irq)
  );

  typedef struct packed {
    logic [7:0] rdata;
    logic       err;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_mis = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit b, input logic req, input logic rw,
                       input logic [7:0] addr, input logic [7:0] wdata);
    if (b) begin b_req = req; b_rw = rw; b_addr = addr; b_wdata = wdata; end
    else   begin a_req = req; a_rw = rw; a_addr = addr; a_wdata = wdata; end
  endtask

  function automatic logic rdy(input bit b);
    return b ? b_ready : a_ready;
  endfunction

  function automatic logic [7:0] rdv(input bit b);
    return b ? b_rdata : a_rdata;
  endfunction

  function automatic logic erv(input bit b);
    return b ? b_err : a_err;
  endfunction

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // One transaction: queue the expectation, wait (bounded) for o_Ready, compare.
  // With pulse set, i_Req is re-asserted as a write of 0xEE while the access is busy.
  task automatic access(input string name, input bit b, input logic rw,
                        input logic [7:0] addr, input logic [7:0] wdata,
                        input logic [7:0] exp_rd, input logic exp_err,
                        input int lat, input bit pulse, output int done_cyc);
    exp_t e;
    int   acc;
    bit   got;
    e = '0;
    @(negedge clk);
    drive(b, 1'b1, rw, addr, wdata);
    sb_q.push_back('{rdata: exp_rd, err: exp_err});
    acc      = cyc + 1;
    got      = 1'b0;
    done_cyc = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (rdy(b)) begin
        got = 1'b1;
        break;
      end
      drive(b, pulse, 1'b1, addr, 8'hEE);
    end
    drive(b, 1'b0, 1'b0, 8'h00, 8'h00);
    if (sb_q.size() > 0) e = sb_q.pop_front();
    check({name, ".ready_seen"}, 32'(got), 32'd1);
    if (got) begin
      done_cyc = cyc;
      check({name, ".latency"}, 32'(cyc - acc), 32'(lat));
      check({name, ".rdata"}, 32'(rdv(b)), 32'(e.rdata));
      check({name, ".err"}, 32'(erv(b)), 32'(e.err));
      @(negedge clk);
      check({name, ".ready_width"}, 32'(rdy(b)), 32'd0);
      check({name, ".rdata_idle"}, 32'(rdv(b)), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish within bound");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int dc;
    int en_cyc;
    int extra;
    a_rst = 1'b1; b_rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    a_pin = 8'h00; b_pin = 8'h00;
    repeat (3) @(negedge clk);
    check("rst.rdata", 32'(a_rdata), 32'd0);
    check("rst.ready", 32'(a_ready), 32'd0);
    check("rst.err", 32'(a_err), 32'd0);
    check("rst.port", 32'(a_port), 32'd0);
    check("rst.irq", 32'(a_irq), 32'd0);
    a_rst = 1'b0; b_rst = 1'b0;

    // RAM write/read, zero wait states
    access("a_wr10", 1'b0, 1'b1, 8'h10, 8'h5A, 8'h00, 1'b0, 1, 1'b0, dc);
    access("a_rd10", 1'b0, 1'b0, 8'h10, 8'h00, 8'h5A, 1'b0, 1, 1'b0, dc);
    access("a_wrBF", 1'b0, 1'b1, 8'hBF, 8'h99, 8'h00, 1'b0, 1, 1'b0, dc);
    access("a_rdBF", 1'b0, 1'b0, 8'hBF, 8'h00, 8'h99, 1'b0, 1, 1'b0, dc);

    // Output port 1 and input synchroniser
    access("a_wrP1", 1'b0, 1'b1, 8'hF1, 8'hA5, 8'h00, 1'b0, 1, 1'b0, dc);
    check("a_port_after", 32'(a_port), 32'h0000A500);
    access("a_rdP1", 1'b0, 1'b0, 8'hF1, 8'h00, 8'hA5, 1'b0, 1, 1'b0, dc);
    a_pin = 8'h3C;
    repeat (2) @(negedge clk);
    access("a_rdPIN", 1'b0, 1'b0, 8'hF8, 8'h00, 8'h3C, 1'b0, 1, 1'b0, dc);

    // Unmapped space, including the RAM_DEPTH boundary and unused IO offsets
    access("a_rdC5", 1'b0, 1'b0, 8'hC5, 8'h00, 8'h00, 1'b1, 1, 1'b0, dc);
    access("a_wrC5", 1'b0, 1'b1, 8'hC5, 8'h77, 8'h00, 1'b1, 1, 1'b0, dc);
    access("a_rdC5b", 1'b0, 1'b0, 8'hC5, 8'h00, 8'h00, 1'b1, 1, 1'b0, dc);
    access("a_rdC0", 1'b0, 1'b0, 8'hC0, 8'h00, 8'h00, 1'b1, 1, 1'b0, dc);
    access("a_rdF3", 1'b0, 1'b0, 8'hF3, 8'h00, 8'h00, 1'b1, 1, 1'b0, dc);

    // Timer: PRESC=4, compare=2 -> flag sets 12 clocks after enable, then every 12
    access("a_rdTCNT0", 1'b0, 1'b0, 8'hFC, 8'h00, 8'h00, 1'b0, 1, 1'b0, dc);
    access("a_wrTCMP", 1'b0, 1'b1, 8'hFD, 8'h02, 8'h00, 1'b0, 1, 1'b0, dc);
    access("a_rdTCMP", 1'b0, 1'b0, 8'hFD, 8'h00, 8'h02, 1'b0, 1, 1'b0, dc);
    access("a_wrEN", 1'b0, 1'b1, 8'hFE, 8'h01, 8'h00, 1'b0, 1, 1'b0, en_cyc);
    wait_until(en_cyc + 11);
    check("irq_before", 32'(a_irq), 32'd0);
    wait_until(en_cyc + 12);
    check("irq_rise", 32'(a_irq), 32'd1);
    access("a_rdTCNT", 1'b0, 1'b0, 8'hFC, 8'h00, 8'h00, 1'b0, 1, 1'b0, dc);
    access("a_rdTCTL", 1'b0, 1'b0, 8'hFE, 8'h00, 8'h03, 1'b0, 1, 1'b0, dc);
    wait_until(en_cyc + 25);
    access("a_w1c", 1'b0, 1'b1, 8'hFE, 8'h03, 8'h00, 1'b0, 1, 1'b0, dc);
    check("irq_cleared", 32'(a_irq), 32'd0);
    wait_until(en_cyc + 33);
    access("a_w1c_coll", 1'b0, 1'b1, 8'hFE, 8'h03, 8'h00, 1'b0, 1, 1'b0, dc);
    check("irq_set_wins", 32'(a_irq), 32'd1);

    // Wait states: latency 4, ignored i_Req pulses yield a single o_Ready
    access("b_wr30", 1'b1, 1'b1, 8'h30, 8'h42, 8'h00, 1'b0, 4, 1'b0, dc);
    access("b_rd30p", 1'b1, 1'b0, 8'h30, 8'h00, 8'h42, 1'b0, 4, 1'b1, dc);
    extra = 0;
    repeat (8) begin
      @(negedge clk);
      if (b_ready) extra++;
    end
    check("b_single_ready", 32'(extra), 32'd0);
    access("b_rd30", 1'b1, 1'b0, 8'h30, 8'h00, 8'h42, 1'b0, 4, 1'b0, dc);

    // Reset during WAIT of a write aborts it without touching RAM
    access("b_wrP0", 1'b1, 1'b1, 8'hF0, 8'h5C, 8'h00, 1'b0, 4, 1'b0, dc);
    check("b_port_after", 32'(b_port), 32'h0000005C);
    access("b_wr20", 1'b1, 1'b1, 8'h20, 8'h11, 8'h00, 1'b0, 4, 1'b0, dc);
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b1, 8'h20, 8'h99);
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    b_rst = 1'b1;
    extra = 0;
    repeat (3) begin
      @(negedge clk);
      if (b_ready) extra++;
    end
    b_rst = 1'b0;
    check("b_abort.rdata", 32'(b_rdata), 32'd0);
    check("b_abort.err", 32'(b_err), 32'd0);
    check("b_abort.port", 32'(b_port), 32'd0);
    check("b_abort.irq", 32'(b_irq), 32'd0);
    repeat (6) begin
      @(negedge clk);
      if (b_ready) extra++;
    end
    check("b_abort.no_ready", 32'(extra), 32'd0);
    access("b_rd20", 1'b1, 1'b0, 8'h20, 8'h00, 8'h11, 1'b0, 4, 1'b0, dc);

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
